// File: rtl/byte_block_assembler_pkg.sv
// Shared types and constants for the byte block assembler.
//   BYTE_W     : width of one stream byte
//   OFFSET_MOD : stream position modulus seen by the encrypter
//   OFFSET_W   : width of the stream position
//   state_e    : FILL (collecting bytes) / HOLD (block presented downstream)
package byte_block_assembler_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned OFFSET_MOD = 256;
    localparam int unsigned OFFSET_W   = $clog2(OFFSET_MOD);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/byte_block_assembler.sv
// Packs a valid/ready byte stream into number_of_bytes-wide blocks and presents
// each block with its starting stream offset and valid-byte count.
// Single-buffered: input is stalled while a finished block waits in HOLD.
//   clk, rst_n         : clock, asynchronous active-low reset
//   restart            : synchronous stream restart, drops partial/held block
//   in_byte/in_valid   : incoming byte and its qualifier
//   in_last            : final byte of the stream, closes a partial block
//   in_ready           : byte can be accepted this cycle (registered)
//   block_data         : packed block, byte i in bits [i*8+7:i*8]
//   block_offset       : stream position (mod 256) of byte 0
//   block_count        : number of valid bytes, 1..number_of_bytes
//   block_last         : block was closed by in_last
//   block_valid        : block outputs valid and stable
//   block_ready        : downstream consumes the block
module byte_block_assembler
    import byte_block_assembler_pkg::*;
#(
    parameter int unsigned number_of_bytes = 256
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  restart,
    input  logic [BYTE_W-1:0]                     in_byte,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic [number_of_bytes*BYTE_W-1:0]     block_data,
    output logic [OFFSET_W-1:0]                   block_offset,
    output logic [$clog2(number_of_bytes+1)-1:0]  block_count,
    output logic                                  block_last,
    output logic                                  block_valid,
    input  logic                                  block_ready
);

    localparam int unsigned CW     = $clog2(number_of_bytes + 1);
    localparam int unsigned DATA_W = number_of_bytes * BYTE_W;

    state_e              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [OFFSET_W-1:0] run_offset_q, run_offset_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [CW-1:0]       count_q, count_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                accept_c;

    // in_ready_q is only ever high in FILL, so it alone qualifies an accept
    assign accept_c = in_valid && ready_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            idx_q        <= '0;
            run_offset_q <= '0;
            data_q       <= '0;
            offset_q     <= '0;
            count_q      <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_offset_q <= run_offset_d;
            data_q       <= data_d;
            offset_q     <= offset_d;
            count_q      <= count_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
            ready_q      <= ready_d;
        end
    end

    // Next-state, packing and offset tracking
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_offset_d = run_offset_q;
        data_d       = data_q;
        offset_d     = offset_q;
        count_d      = count_q;
        last_d       = last_q;

        if (restart) begin
            // Overrides any accept or consume in the same cycle
            state_d      = FILL;
            idx_d        = '0;
            run_offset_d = '0;
            data_d       = '0;
            count_d      = '0;
            last_d       = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept_c) begin
                        data_d[BYTE_W*32'(idx_q) +: BYTE_W] = in_byte;
                        idx_d = idx_q + CW'(1);
                        if ((idx_q == CW'(number_of_bytes - 1)) || in_last) begin
                            state_d  = HOLD;
                            count_d  = idx_q + CW'(1);
                            last_d   = in_last;
                            offset_d = run_offset_q;
                        end
                    end
                end
                HOLD: begin
                    if (block_ready) begin
                        state_d      = FILL;
                        // A closed stream restarts numbering at zero
                        run_offset_d = last_q ? '0 : run_offset_q + OFFSET_W'(count_q);
                        idx_d        = '0;
                        data_d       = '0;
                        count_d      = '0;
                        last_d       = 1'b0;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        valid_d = (state_d == HOLD);
        ready_d = (state_d == FILL);
    end

    assign in_ready     = ready_q;
    assign block_data   = data_q;
    assign block_offset = offset_q;
    assign block_count  = count_q;
    assign block_last   = last_q;
    assign block_valid  = valid_q;

endmodule

// File: tb/tb_byte_block_assembler.sv
// Randomized directed bench for byte_block_assembler with number_of_bytes=4.
// Expected blocks come from a byte-queue model of the stream.
module tb_byte_block_assembler;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            restart = 1'b0;
    logic [7:0]      in_byte = '0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            in_ready;
    logic [N*8-1:0]  block_data;
    logic [7:0]      block_offset;
    logic [CW-1:0]   block_count;
    logic            block_last;
    logic            block_valid;
    logic            block_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [7:0]  cur[$];
    int          model_off = 0;
    logic        pending = 1'b0;
    logic [63:0] e_data = '0;
    int          e_cnt = 0;
    int          e_off = 0;
    logic        e_last = 1'b0;

    byte_block_assembler #(.number_of_bytes(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .block_data   (block_data),
        .block_offset (block_offset),
        .block_count  (block_count),
        .block_last   (block_last),
        .block_valid  (block_valid),
        .block_ready  (block_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic void model_clear();
        cur.delete();
        model_off = 0;
        pending   = 1'b0;
    endfunction

    function automatic void model_push(input logic [7:0] b, input logic last);
        cur.push_back(b);
        if (cur.size() == N || last) begin
            e_data = '0;
            foreach (cur[i]) e_data[i*8 +: 8] = cur[i];
            e_cnt   = cur.size();
            e_off   = model_off % 256;
            e_last  = last;
            pending = 1'b1;
            cur.delete();
        end
    endfunction

    // Offer one byte until accepted (bounded), then check block_valid latency
    task automatic send_byte(input logic [7:0] b, input logic last);
        logic acc;
        acc      = 1'b0;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (in_ready === 1'b1) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("accept_timeout", 64'(acc), 64'(1));
        if (acc) begin
            model_push(b, last);
            chk("valid_after_byte", 64'(block_valid), 64'(pending));
            chk("ready_after_byte", 64'(in_ready), 64'(!pending));
        end
    endtask

    task automatic send_block(input int n, input logic last);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), last && (i == n - 1));
    endtask

    task automatic check_block(input string tag);
        chk({tag, "_valid"},  64'(block_valid),  64'(1));
        chk({tag, "_data"},   64'(block_data),   e_data);
        chk({tag, "_offset"}, 64'(block_offset), 64'(e_off));
        chk({tag, "_count"},  64'(block_count),  64'(e_cnt));
        chk({tag, "_last"},   64'(block_last),   64'(e_last));
    endtask

    // Check the held block, take it in one cycle, check return to FILL
    task automatic consume(input string tag);
        check_block(tag);
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(block_valid), 64'(0));
        chk({tag, "_ready_back"}, 64'(in_ready), 64'(1));
        chk({tag, "_data_clr"},   64'(block_data), 64'(0));
        model_off = e_last ? 0 : (model_off + e_cnt) % 256;
        pending   = 1'b0;
    endtask

    initial begin
        logic [N*8-1:0] held_data;
        int             n;
        logic           lst;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready),     64'(0));
        chk("rst_valid",    64'(block_valid),  64'(0));
        chk("rst_data",     64'(block_data),   64'(0));
        chk("rst_offset",   64'(block_offset), 64'(0));
        chk("rst_count",    64'(block_count),  64'(0));
        chk("rst_last",     64'(block_last),   64'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_rise", 64'(in_ready), 64'(1));

        // Full block with known bytes, then next block offset 4
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        chk("full_data_const", 64'(block_data), 64'h44332211);
        consume("full");
        send_block(N, 1'b0);
        chk("second_offset", 64'(block_offset), 64'(4));
        consume("second");

        // Partial block closed by in_last, next stream starts at 0
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        chk("partial_data_const", 64'(block_data), 64'h0000BBAA);
        chk("partial_count_const", 64'(block_count), 64'(2));
        consume("partial");
        send_block(N, 1'b0);
        chk("after_last_offset", 64'(block_offset), 64'(0));
        consume("after_last");

        // in_last on the first byte, and on the filling byte
        send_block(1, 1'b1);
        consume("single_last");
        send_block(N, 1'b1);
        consume("full_last");

        // Backpressure: held block stays frozen while in_valid pushes
        send_block(N, 1'b0);
        held_data = block_data;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready),   64'(0));
            chk("bp_data",     64'(block_data), 64'(held_data));
            check_block("bp");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume("bp_release");

        // Random block lengths, last flags and consume delays
        for (int b = 0; b < 24; b++) begin
            n   = $urandom_range(1, N);
            lst = (n < N) ? 1'b1 : 1'($urandom_range(0, 1));
            send_block(n, lst);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rand_hold_valid", 64'(block_valid), 64'(1));
            end
            consume("rand");
        end

        // Restart mid-fill with a simultaneous byte: only new bytes survive
        send_block(N, 1'b0);
        consume("pre_restart");
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        restart  = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("restart_fill_data", 64'(block_data), 64'(0));
        send_block(N, 1'b0);
        consume("post_restart_fill");

        // Restart in HOLD together with block_ready: block dropped, offset 0
        send_block(N, 1'b0);
        restart     = 1'b1;
        block_ready = 1'b1;
        @(negedge clk);
        restart     = 1'b0;
        block_ready = 1'b0;
        model_clear();
        chk("restart_hold_valid", 64'(block_valid), 64'(0));
        chk("restart_hold_ready", 64'(in_ready),    64'(1));
        send_block(N, 1'b0);
        chk("restart_hold_next_off", 64'(block_offset), 64'(0));
        consume("post_restart_hold");

        // Offset wrap over 65 full blocks
        send_block(1, 1'b1);
        consume("wrap_prep");
        for (int i = 0; i < 65; i++) begin
            send_block(N, 1'b0);
            if (i == 63) chk("wrap_blk63_off", 64'(block_offset), 64'(252));
            if (i == 64) chk("wrap_blk64_off", 64'(block_offset), 64'(0));
            consume("wrap");
        end

        // Asynchronous reset between edges, mid-fill
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready),     64'(0));
        chk("arst_valid",    64'(block_valid),  64'(0));
        chk("arst_data",     64'(block_data),   64'(0));
        chk("arst_offset",   64'(block_offset), 64'(0));
        chk("arst_count",    64'(block_count),  64'(0));
        chk("arst_last",     64'(block_last),   64'(0));
        model_clear();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        chk("arst_new_data", 64'(block_data), 64'hC4C3C2C1);
        consume("arst_new");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/byte_block_assembler.md
Name: byte_block_assembler

Overview:
- Upstream stage of the combinational multi-byte encrypter.
- Accepts a serial byte stream over a valid/ready handshake and packs bytes into an N-byte block.
- Tracks the running stream position (mod 256) and presents each block with its starting offset and valid-byte count to the encrypter, with a valid/ready handshake on the output side.
- Single-buffered: the input is stalled while a finished block waits to be taken.

Parameters:
- number_of_bytes, 256, bytes per block. Must be ≥2. Sets the output bus width: number_of_bytes*8.
- CW, $clog2(number_of_bytes+1), width of the byte count. Derived; not for override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- restart  input  1  synchronous stream restart: clears the offset and discards any partial or held block.
- in_byte  input  8  incoming byte.
- in_valid  input  1  in_byte is valid this cycle.
- in_last  input  1  qualifies in_byte as the final byte of the stream; closes a partial block.
- in_ready  output  1  assembler can accept a byte this cycle.
- block_data  output  number_of_bytes*8  packed block; byte i occupies bits [i*8+7 : i*8].
- block_offset  output  8  stream position of byte 0 of the block; feeds the encrypter offset input.
- block_count  output  CW  number of valid bytes in the block, range 1..number_of_bytes.
- block_last  output  1  block was closed by in_last.
- block_valid  output  1  block outputs are stable and valid.
- block_ready  input  1  downstream consumes the block.

Behaviour:
- Reset (rst_n low, asynchronous): state FILL, idx=0, run_offset=0, block_data=0, block_offset=0, block_count=0, block_last=0, block_valid=0, in_ready=0 during reset.
- in_ready is a registered output. It is 1 in FILL from the first clock after reset release.
- States:
  - FILL: in_ready=1, block_valid=0.
  - HOLD: in_ready=0, block_valid=1.
- Input acceptance: a byte is accepted when in_valid & in_ready. On accept:
  - block_data byte[idx] ← in_byte.
  - idx ← idx+1.
- FILL→HOLD transition, on an accept where idx==number_of_bytes-1 or in_last=1:
  - block_count ← idx+1.
  - block_last ← in_last.
  - block_offset ← run_offset.
  - block_valid rises the next cycle.
- Unwritten bytes of a partial block read as 0. block_data is cleared to 0 when the block is consumed.
- HOLD→FILL transition, when block_ready=1 (block_valid is already 1):
  - run_offset ← (run_offset + block_count) mod 256.
  - If block_last=1, run_offset ← 0 instead, so the next stream starts at offset 0.
  - idx←0; block_data, block_count and block_last cleared.
- in_valid during HOLD is ignored; upstream must hold its byte.
- Output stability: block outputs are stable throughout HOLD.
- Latency: the last byte is accepted in cycle t; block_valid=1 in t+1. Minimum turnaround is one HOLD cycle, so full-speed throughput is N bytes per N+1 cycles.
- Offset arithmetic: 8-bit, wraps mod 256 (e.g. 254+4 → 2). Counts are not limited to 256 when number_of_bytes>256.
- restart=1 (synchronous) has priority over all other events in the same cycle, including an accept or a consume. Result:
  - FILL, idx=0, run_offset=0, block_data=0.
  - block_valid=0; the held block is dropped without handshake.
- in_last with idx=0 yields block_count=1.
- in_last on the byte that also fills the block yields block_count=N and block_last=1.
- block_ready while in FILL is ignored.

Decomposition:
- Shared package holds:
  - state enum {FILL, HOLD};
  - a BYTE_W=8 constant;
  - the offset modulus constant (256).
- No sub-module. Packing, control and offset tracking form one flat FSM. The encrypter is instantiated alongside it by the parent, not inside this block.

Test Plan (number_of_bytes=4):
- Full block: send 0x11,0x22,0x33,0x44, block_ready=1 → block_data=0x44332211, block_offset=0, block_count=4, block_last=0. block_valid is high for exactly 1 cycle, then the next block has block_offset=4.
- Partial/last: send 0xAA, 0xBB with in_last → block_data=0x0000BBAA, block_count=2, block_last=1. After consume, the next block_offset=0.
- Backpressure: with block_ready=0, complete a block and drive in_valid for 5 more cycles → in_ready=0 and outputs unchanged throughout. Raise block_ready → one-cycle consume, then in_ready=1.
- Wrap: stream 65 full blocks → block 64 has block_offset=0 (256 mod 256). Block 63 has block_offset=252.
- Restart in HOLD with block_ready=1 the same cycle → block_valid=0 next cycle, run_offset=0, no consume counted. The next block has offset 0.
- Async reset mid-fill (2 bytes in), rst_n low between clock edges → all outputs 0 immediately. After release, 4 new bytes produce block_offset=0 containing only the new bytes.
